// File: rtl/dircc_node_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : dircc_node_mem_loader_if
// Description : Bundles the node memory port and the host loader stream of
//               one DiRCC node memory. The loader block uses the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dircc_node_mem_loader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    // Node memory port
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              node_reset_n;
    // Host loader stream
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_len;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;
    logic [DATA_W-1:0] load_sum;
    logic              load_error;

    modport master (
        output mem_address, mem_write, mem_writedata,
        output load_start, load_base, load_len, load_valid, load_data,
        input  mem_readdata, node_reset_n,
        input  load_ready, load_busy, load_done, load_sum, load_error
    );

    modport slave (
        input  mem_address, mem_write, mem_writedata,
        input  load_start, load_base, load_len, load_valid, load_data,
        output mem_readdata, node_reset_n,
        output load_ready, load_busy, load_done, load_sum, load_error
    );
endinterface
`default_nettype wire

// File: rtl/dircc_node_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : dircc_node_mem_loader
// Description : Per-node RAM that holds its node in reset, streams a host
//               image into memory with a running checksum, releases the node
//               after a settle delay and then serves node reads/writes.
// Revision    : 1.0 - initial release
// ============================================================================
module dircc_node_mem_loader #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 16,
    parameter int RELEASE_CYCLES = 4
) (
    input  wire logic              clk_clk,
    input  wire logic              reset_reset_n,
    dircc_node_mem_loader_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int RC_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [RC_W-1:0] c_RC_INIT    = RC_W'(RELEASE_CYCLES - 1);
    localparam logic [ADDR_W:0] c_REMAIN_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W:0]   r_remain;
    logic [RC_W-1:0]   r_rel_cnt;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_node_rst_n;
    logic              r_error;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_ram [DEPTH];

    logic w_accept;
    logic w_node_wr;

    // A host word is taken only while loading and advertising ready
    assign w_accept  = (r_state == ST_LOAD) && r_ready && bus.load_valid;
    // The node may only write once it has been released from reset
    assign w_node_wr = (r_state == ST_RUN) && bus.mem_write;

    // Load/release sequencer; all status outputs are registered here
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= ST_HOLD;
            r_waddr      <= '0;
            r_remain     <= '0;
            r_rel_cnt    <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_node_rst_n <= 1'b0;
            r_error      <= 1'b0;
            r_sum        <= '0;
        end else begin
            r_done <= 1'b0;
            // A start arriving mid-load is dropped but remembered as an error
            if (bus.load_start && (r_state == ST_LOAD || r_state == ST_RELEASE)) begin
                r_error <= 1'b1;
            end
            case (r_state)
                ST_HOLD, ST_RUN: begin
                    if (bus.load_start) begin
                        r_waddr      <= bus.load_base;
                        r_remain     <= bus.load_len;
                        r_sum        <= '0;
                        r_error      <= 1'b0;
                        r_node_rst_n <= 1'b0;
                        r_busy       <= 1'b1;
                        if (bus.load_len == '0) begin
                            r_state   <= ST_RELEASE;
                            r_rel_cnt <= c_RC_INIT;
                            r_ready   <= 1'b0;
                        end else begin
                            r_state <= ST_LOAD;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        // Address wraps naturally at the RAM size
                        r_waddr  <= r_waddr + ADDR_W'(1);
                        r_remain <= r_remain - (ADDR_W + 1)'(1);
                        r_sum    <= r_sum + bus.load_data;
                        if (r_remain == c_REMAIN_ONE) begin
                            r_ready   <= 1'b0;
                            r_state   <= ST_RELEASE;
                            r_rel_cnt <= c_RC_INIT;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_rel_cnt == '0) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b0;
                        r_node_rst_n <= 1'b1;
                        r_done       <= 1'b1;
                    end else begin
                        r_rel_cnt <= r_rel_cnt - RC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    // RAM write port shared by the loader and the running node (never both)
    always_ff @(posedge clk_clk) begin
        if (w_accept) begin
            r_ram[r_waddr] <= bus.load_data;
        end else if (w_node_wr) begin
            r_ram[bus.mem_address] <= bus.mem_writedata;
        end
    end

    // Registered read port; same-address write in the same cycle returns old data
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_ram[bus.mem_address];
        end
    end

    assign bus.mem_readdata = r_rdata;
    assign bus.node_reset_n = r_node_rst_n;
    assign bus.load_ready   = r_ready;
    assign bus.load_busy    = r_busy;
    assign bus.load_done    = r_done;
    assign bus.load_sum     = r_sum;
    assign bus.load_error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dircc_node_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dircc_node_mem_loader
// Description : Self-checking bench for dircc_node_mem_loader: directed load
//               scenarios, a node-access vector table, randomized loads and
//               node traffic compared against an array-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dircc_node_mem_loader;

    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 16;
    localparam int RELEASE_CYCLES = 4;
    localparam int DEPTH          = 1 << ADDR_W;

    logic clk_clk       = 1'b0;
    logic reset_reset_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory: contents plus a flag saying the word is known
    logic [DATA_W-1:0] model_ram [DEPTH];
    bit                model_ok  [DEPTH];

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t tbl [7];

    dircc_node_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dircc_node_mem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .bus(bus)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    // Runs one complete load from HOLD or RUN and checks handshake, timing, sum
    task automatic run_load(input logic [ADDR_W-1:0] base, input int len, input int gap_pct,
                            input bit fixed, input int err_at, input string tag);
        int                k;
        int                guard;
        int                cyc;
        bit                ready_held;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        bus.load_base  = base;
        bus.load_len   = (ADDR_W + 1)'(len);
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check({tag, " busy_after_start"}, 32'(bus.load_busy), 32'd1);
        check({tag, " node_rst_after_start"}, 32'(bus.node_reset_n), 32'd0);
        check({tag, " error_cleared"}, 32'(bus.load_error), 32'd0);
        check({tag, " sum_cleared"}, 32'(bus.load_sum), 32'd0);
        k = 0;
        guard = 0;
        ready_held = 1'b1;
        sum = '0;
        while (k < len && guard < 4 * len + 64) begin
            d = fixed ? DATA_W'(k + 1) : DATA_W'($urandom);
            bus.load_data  = d;
            bus.load_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.load_start = (k == err_at);
            if (bus.load_start) begin
                bus.load_base = ADDR_W'($urandom);
                bus.load_len  = (ADDR_W + 1)'($urandom_range(1, 9));
            end
            if (bus.load_ready !== 1'b1) ready_held = 1'b0;
            if (bus.load_valid) begin
                a = base + ADDR_W'(k);
                model_ram[a] = d;
                model_ok[a]  = 1'b1;
                sum = sum + d;
                k++;
            end
            step();
            guard++;
        end
        bus.load_valid = 1'b0;
        bus.load_start = 1'b0;
        check({tag, " words_accepted"}, 32'(k), 32'(len));
        check({tag, " ready_held"}, 32'(ready_held), 32'd1);
        check({tag, " ready_dropped"}, 32'(bus.load_ready), 32'd0);
        cyc = 0;
        while (bus.node_reset_n !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, " release_cycles"}, 32'(cyc), 32'(RELEASE_CYCLES));
        check({tag, " done_pulse"}, 32'(bus.load_done), 32'd1);
        check({tag, " busy_in_run"}, 32'(bus.load_busy), 32'd0);
        check({tag, " sum"}, 32'(bus.load_sum), 32'(sum));
        check({tag, " error"}, 32'(bus.load_error), 32'(err_at >= 0 && err_at < len));
        step();
        check({tag, " done_single"}, 32'(bus.load_done), 32'd0);
    endtask

    // Reads one address through the node port and compares with the model
    task automatic readback(input logic [ADDR_W-1:0] a, input string tag);
        bus.mem_address = a;
        bus.mem_write   = 1'b0;
        step();
        if (model_ok[a]) check({tag, " readback"}, 32'(bus.mem_readdata), 32'(model_ram[a]));
    endtask

    // Random node reads/writes within a window, one-cycle read latency, old-data on collision
    task automatic node_traffic(input int n, input logic [ADDR_W-1:0] lo, input int span);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp;
        bit                we;
        bit                ok;
        for (int i = 0; i < n; i++) begin
            a  = lo + ADDR_W'($urandom_range(0, span - 1));
            we = 1'($urandom_range(0, 1));
            wd = DATA_W'($urandom);
            bus.mem_address   = a;
            bus.mem_write     = we;
            bus.mem_writedata = wd;
            exp = model_ram[a];
            ok  = model_ok[a];
            step();
            if (ok) check("node_rw", 32'(bus.mem_readdata), 32'(exp));
            if (we) begin
                model_ram[a] = wd;
                model_ok[a]  = 1'b1;
            end
        end
        bus.mem_write = 1'b0;
    endtask

    initial begin : main
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] d;
        int                len;

        // Node access vectors after loading 1,2,3,4 at address 0
        tbl[0] = '{we: 1'b0, addr: 15'd2, wd: 16'h0000, exp: 16'd3};
        tbl[1] = '{we: 1'b1, addr: 15'd2, wd: 16'hBEEF, exp: 16'd3};
        tbl[2] = '{we: 1'b0, addr: 15'd2, wd: 16'h0000, exp: 16'hBEEF};
        tbl[3] = '{we: 1'b1, addr: 15'd0, wd: 16'h1234, exp: 16'd1};
        tbl[4] = '{we: 1'b0, addr: 15'd0, wd: 16'h0000, exp: 16'h1234};
        tbl[5] = '{we: 1'b0, addr: 15'd3, wd: 16'h0000, exp: 16'd4};
        tbl[6] = '{we: 1'b0, addr: 15'd1, wd: 16'h0000, exp: 16'd2};

        bus.mem_address   = '0;
        bus.mem_write     = 1'b0;
        bus.mem_writedata = '0;
        bus.load_start    = 1'b0;
        bus.load_base     = '0;
        bus.load_len      = '0;
        bus.load_valid    = 1'b0;
        bus.load_data     = '0;

        // Reset state
        repeat (3) @(posedge clk_clk);
        #1;
        check("rst node_reset_n", 32'(bus.node_reset_n), 32'd0);
        check("rst load_ready", 32'(bus.load_ready), 32'd0);
        check("rst load_busy", 32'(bus.load_busy), 32'd0);
        check("rst load_done", 32'(bus.load_done), 32'd0);
        check("rst load_sum", 32'(bus.load_sum), 32'd0);
        check("rst load_error", 32'(bus.load_error), 32'd0);
        check("rst mem_readdata", 32'(bus.mem_readdata), 32'd0);
        #2 reset_reset_n = 1'b1;
        step();
        check("hold node_reset_n", 32'(bus.node_reset_n), 32'd0);

        // Basic back-to-back load of 1,2,3,4
        run_load(15'd0, 4, 0, 1'b1, -1, "t1");
        check("t1 sum_is_10", 32'(bus.load_sum), 32'd10);

        // Node reads and writes in RUN, including read-during-write
        for (int i = 0; i < 7; i++) begin
            bus.mem_address   = tbl[i].addr;
            bus.mem_write     = tbl[i].we;
            bus.mem_writedata = tbl[i].wd;
            step();
            check($sformatf("t2 vec%0d", i), 32'(bus.mem_readdata), 32'(tbl[i].exp));
            if (tbl[i].we) begin
                model_ram[tbl[i].addr] = tbl[i].wd;
                model_ok[tbl[i].addr]  = 1'b1;
            end
        end
        bus.mem_write = 1'b0;

        // Wrap across the top of memory with valid gaps
        run_load(15'h7FFE, 4, 50, 1'b0, -1, "t3");
        readback(15'h7FFE, "t3");
        readback(15'h7FFF, "t3");
        readback(15'h0000, "t3");
        readback(15'h0001, "t3");

        // Zero-length load
        run_load(15'h0123, 0, 0, 1'b0, -1, "t4");

        // Start during LOAD is ignored and flagged; next start from RUN clears it
        run_load(15'h0100, 6, 30, 1'b0, 2, "t5");
        for (int i = 0; i < 6; i++) readback(15'h0100 + 15'(i), "t5");
        run_load(15'h0200, 3, 0, 1'b0, -1, "t5b");

        // Randomized loads followed by node traffic in the loaded window
        for (int r = 0; r < 6; r++) begin
            base = ADDR_W'($urandom);
            len  = $urandom_range(1, 40);
            run_load(base, len, $urandom_range(0, 60), 1'b0,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1, "rnd");
            node_traffic(40, base, len);
            for (int i = 0; i < 4; i++) readback(base + ADDR_W'($urandom_range(0, len - 1)), "rnd");
        end

        // Full-depth load from an arbitrary base fills the whole RAM once
        base = ADDR_W'($urandom);
        run_load(base, DEPTH, 0, 1'b0, -1, "full");
        readback(base, "full");
        readback(base - ADDR_W'(1), "full");
        for (int i = 0; i < 32; i++) readback(ADDR_W'($urandom), "full");

        // Reset in the middle of a load
        bus.load_base  = 15'h0040;
        bus.load_len   = 16'd4;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = DATA_W'($urandom);
            bus.load_valid = 1'b1;
            bus.load_data  = d;
            bus.load_start = (i == 1);
            model_ram[15'h0040 + 15'(i)] = d;
            model_ok[15'h0040 + 15'(i)]  = 1'b1;
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_start = 1'b0;
        check("t6 error_before_reset", 32'(bus.load_error), 32'd1);
        #2 reset_reset_n = 1'b0;
        #1;
        check("t6 node_reset_n", 32'(bus.node_reset_n), 32'd0);
        check("t6 load_ready", 32'(bus.load_ready), 32'd0);
        check("t6 load_busy", 32'(bus.load_busy), 32'd0);
        check("t6 load_done", 32'(bus.load_done), 32'd0);
        check("t6 load_sum", 32'(bus.load_sum), 32'd0);
        check("t6 load_error", 32'(bus.load_error), 32'd0);
        check("t6 mem_readdata", 32'(bus.mem_readdata), 32'd0);
        #3 reset_reset_n = 1'b1;
        step();
        readback(15'h0040, "t6");
        readback(15'h0041, "t6");

        // Node writes are ignored while held in reset
        bus.mem_address   = 15'h0040;
        bus.mem_write     = 1'b1;
        bus.mem_writedata = ~model_ram[15'h0040];
        step();
        bus.mem_write = 1'b0;
        step();
        check("t6 hold_write_ignored", 32'(bus.mem_readdata), 32'(model_ram[15'h0040]));

        // Block is back in HOLD: a fresh load proceeds normally
        run_load(15'h0050, 2, 20, 1'b0, -1, "t6b");
        readback(15'h0050, "t6b");
        readback(15'h0051, "t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
